// File: rtl/matrix_io_pkg.sv
// Shared ASCII constants, parser state encoding and byte classifiers for the
// matrix text I/O blocks (used by the input parser and the output formatter).
package matrix_io_pkg;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
    SKIP = 2'd2
  } mip_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_delim(input logic [7:0] b);
    return (b == ASCII_SP) || (b == ASCII_TAB) || (b == ASCII_COMMA);
  endfunction

endpackage

// File: rtl/mip_dec_acc.sv
// Combinational decimal accumulate step: acc*10 + digit, clamped to the legal
// range. MATRIX_PARSER_SIGNED_EN widens the negative limit to 2^(DATA_W-1).
module mip_dec_acc #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [3:0]        digit_i,
`ifdef MATRIX_PARSER_SIGNED_EN
  input  logic              neg_i,
`endif
  output logic [DATA_W-1:0] acc_o,
  output logic              ovf_o
);

  localparam int WIDE_W = DATA_W + 4;

  logic [WIDE_W-1:0] wide_s;
  logic [WIDE_W-1:0] limit_s;

  // Compute the widened product-sum and compare against the magnitude limit.
  always_comb begin
    wide_s = ({4'd0, acc_i} * WIDE_W'(10)) + {{DATA_W{1'b0}}, digit_i};
`ifdef MATRIX_PARSER_SIGNED_EN
    // Magnitude is held unsigned; negatives may reach one step further.
    if (neg_i) begin
      limit_s = WIDE_W'(1) << (DATA_W - 1);
    end else begin
      limit_s = (WIDE_W'(1) << (DATA_W - 1)) - WIDE_W'(1);
    end
`else
    limit_s = {4'd0, {DATA_W{1'b1}}};
`endif
    if (wide_s > limit_s) begin
      ovf_o = 1'b1;
      acc_o = limit_s[DATA_W-1:0];
    end else begin
      ovf_o = 1'b0;
      acc_o = wide_s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/matrix_input_parser.sv
// ASCII decimal matrix parser: bytes in, row/column tagged elements out.
// Optional signed input via MATRIX_PARSER_SIGNED_EN.
module matrix_input_parser
  import matrix_io_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_ROWS = 16,
  parameter int MAX_COLS = 16,
  localparam int ROW_W   = $clog2(MAX_ROWS),
  localparam int COL_W   = $clog2(MAX_COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_row_end,
  output logic              frame_done,
  output logic              err,
  input  logic              err_clr
);

  mip_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              col_full_q, col_full_d;
  logic              err_q, err_d;
  logic              frame_q, frame_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ROW_W-1:0]  out_row_q, out_row_d;
  logic [COL_W-1:0]  out_col_q, out_col_d;
  logic              out_row_end_q, out_row_end_d;
`ifdef MATRIX_PARSER_SIGNED_EN
  logic              neg_q, neg_d;
  logic              dig_q, dig_d;
`endif

  logic              accept_s;
  logic              is_lf_s;
  logic              tok_ok_s;
  logic              emit_s;
  logic              row_end_s;
  logic              frame_s;
  logic              row_adv_s;
  logic              err_set_s;
  logic [DATA_W-1:0] acc_in_s;
  logic [DATA_W-1:0] acc_nxt_s;
  logic              acc_ovf_s;
  logic [DATA_W-1:0] elem_s;

  assign in_ready = rst_n & (~out_valid_q | out_ready);
  assign accept_s = in_valid & in_ready;
  assign is_lf_s  = (in_data == ASCII_LF);
  assign acc_in_s = (state_q == NUM) ? acc_q : '0;

  mip_dec_acc #(.DATA_W(DATA_W)) u_dec_acc (
    .acc_i   (acc_in_s),
    .digit_i (in_data[3:0]),
`ifdef MATRIX_PARSER_SIGNED_EN
    .neg_i   ((state_q == NUM) & neg_q),
`endif
    .acc_o   (acc_nxt_s),
    .ovf_o   (acc_ovf_s)
  );

`ifdef MATRIX_PARSER_SIGNED_EN
  assign tok_ok_s = dig_q;
  assign elem_s   = neg_q ? (~acc_q + DATA_W'(1)) : acc_q;
`else
  assign tok_ok_s = 1'b1;
  assign elem_s   = acc_q;
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
      col_full_q    <= 1'b0;
      err_q         <= 1'b0;
      frame_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_row_q     <= '0;
      out_col_q     <= '0;
      out_row_end_q <= 1'b0;
`ifdef MATRIX_PARSER_SIGNED_EN
      neg_q         <= 1'b0;
      dig_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      row_q         <= row_d;
      col_q         <= col_d;
      col_full_q    <= col_full_d;
      err_q         <= err_d;
      frame_q       <= frame_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_row_q     <= out_row_d;
      out_col_q     <= out_col_d;
      out_row_end_q <= out_row_end_d;
`ifdef MATRIX_PARSER_SIGNED_EN
      neg_q         <= neg_d;
      dig_q         <= dig_d;
`endif
    end
  end

  // Token parser: next state, position counters and element/frame requests.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    row_d      = row_q;
    col_d      = col_q;
    col_full_d = col_full_q;
    err_set_s  = 1'b0;
    emit_s     = 1'b0;
    row_end_s  = 1'b0;
    frame_s    = 1'b0;
    row_adv_s  = 1'b0;
`ifdef MATRIX_PARSER_SIGNED_EN
    neg_d      = neg_q;
    dig_d      = dig_q;
`endif
    if (!accept_s) begin
      state_d = state_q;
    end else if (is_digit(in_data)) begin
      if (state_q != SKIP) begin
        state_d   = NUM;
        acc_d     = acc_nxt_s;
        err_set_s = acc_ovf_s;
`ifdef MATRIX_PARSER_SIGNED_EN
        dig_d     = 1'b1;
        neg_d     = (state_q == NUM) & neg_q;
`endif
      end else begin
        state_d = SKIP;
      end
    end else if (is_delim(in_data) || is_lf_s) begin
      case (state_q)
        NUM: begin
          // col_full marks that column MAX_COLS-1 has already been used.
          if (!tok_ok_s || col_full_q) begin
            err_set_s = 1'b1;
          end else begin
            emit_s    = 1'b1;
            row_end_s = is_lf_s;
            if (is_lf_s) begin
              col_d = col_q;
            end else if (col_q == COL_W'(MAX_COLS - 1)) begin
              col_full_d = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
          row_adv_s = is_lf_s;
          state_d   = IDLE;
          acc_d     = '0;
        end
        SKIP: begin
          row_adv_s = is_lf_s;
          state_d   = IDLE;
        end
        IDLE: begin
          if (!is_lf_s) begin
            state_d = IDLE;
          end else if ((col_q != '0) || col_full_q) begin
            row_adv_s = 1'b1;
          end else if (row_q != '0) begin
            frame_s = 1'b1;
            row_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      if (row_adv_s) begin
        col_d      = '0;
        col_full_d = 1'b0;
        if (row_q == ROW_W'(MAX_ROWS - 1)) begin
          row_d     = '0;
          err_set_s = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        row_adv_s = 1'b0;
      end
    end else if (in_data == ASCII_CR) begin
      state_d = state_q;
    end
`ifdef MATRIX_PARSER_SIGNED_EN
    else if ((in_data == ASCII_MINUS) && (state_q == IDLE)) begin
      state_d = NUM;
      acc_d   = '0;
      neg_d   = 1'b1;
      dig_d   = 1'b0;
    end
`endif
    else begin
      err_set_s = 1'b1;
      acc_d     = '0;
      state_d   = SKIP;
    end
  end

  // Output holding register, frame pulse and sticky error.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_row_d     = out_row_q;
    out_col_d     = out_col_q;
    out_row_end_d = out_row_end_q;
    if (emit_s) begin
      out_valid_d   = 1'b1;
      out_data_d    = elem_s;
      out_row_d     = row_q;
      out_col_d     = col_q;
      out_row_end_d = row_end_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    frame_d = frame_s;
    err_d   = err_set_s | (err_q & ~err_clr);
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign out_row_end = out_row_end_q;
  assign frame_done  = frame_q;
  assign err         = err_q;

endmodule

// File: tb/tb_matrix_input_parser.sv
// Directed bench for matrix_input_parser; signed checks follow MATRIX_PARSER_SIGNED_EN.
module tb_matrix_input_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       in_ready, out_valid, out_row_end, frame_done, err;
  logic [7:0] out_data;
  logic [3:0] out_row, out_col;

  int vectors = 0;
  int miscompares = 0;
  int frame_cnt = 0;
  int qb = 0;
  int fb = 0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  matrix_input_parser dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_row_end(out_row_end), .frame_done(frame_done), .err(err),
    .err_clr(err_clr)
  );

  // Records every element transfer and frame pulse, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready)
      got_q.push_back({15'd0, out_row_end, out_row, out_col, out_data});
    if (frame_done) frame_cnt++;
  end

  function automatic logic [31:0] el(input logic re, input logic [3:0] r,
                                     input logic [3:0] c, input logic [7:0] d);
    return {15'd0, re, r, c, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_elem(input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = (qb + idx < got_q.size()) ? got_q[qb + idx] : 32'hDEAD_BEEF;
    chk($sformatf("elem%0d", idx), got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    qb = got_q.size();
    fb = frame_cnt;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'd0);
    chk("rst_row_end", out_row_end, 1'b0);
    chk("rst_frame", frame_done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Basic matrix with blank-line frame end
    send_str("12 34\n5 6\n\n");
    idle(3);
    chk("t1_count", got_q.size() - qb, 32'd4);
    chk_elem(0, el(1'b0, 4'd0, 4'd0, 8'd12));
    chk_elem(1, el(1'b1, 4'd0, 4'd1, 8'd34));
    chk_elem(2, el(1'b0, 4'd1, 4'd0, 8'd5));
    chk_elem(3, el(1'b1, 4'd1, 4'd1, 8'd6));
    chk("t1_frame", frame_cnt - fb, 32'd1);
    chk("t1_err", err, 1'b0);

    // CR ignored
    do_reset();
    send_byte(8'h39); send_byte(8'h0D); send_byte(8'h0A);
    idle(3);
    chk("cr_count", got_q.size() - qb, 32'd1);
    chk_elem(0, el(1'b1, 4'd0, 4'd0, 8'd9));
    chk("cr_err", err, 1'b0);

    // Backpressure: "7,8\n" with out_ready low for 5 cycles
    do_reset();
    out_ready = 1'b0;
    send_byte(8'h37); send_byte(8'h2C);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h38;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, 8'd7);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send_byte(8'h0A);
    idle(3);
    chk("t2_count", got_q.size() - qb, 32'd2);
    chk_elem(0, el(1'b0, 4'd0, 4'd0, 8'd7));
    chk_elem(1, el(1'b1, 4'd0, 4'd1, 8'd8));

    // Value saturation, err_clr, and err_clr colliding with a new error
    do_reset();
    send_str("300 2\n");
    idle(2);
    chk_elem(0, el(1'b0, 4'd0, 4'd0, 8'd255));
    chk_elem(1, el(1'b1, 4'd0, 4'd1, 8'd2));
    chk("t3_err_set", err, 1'b1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    chk("t3_err_clr", err, 1'b0);
    err_clr = 1'b1;
    send_byte(8'h78);
    err_clr = 1'b0;
    chk("t3_err_clr_vs_set", err, 1'b1);

    // Bad token skipped
    do_reset();
    send_str("1a2 7\n");
    idle(3);
    chk("t4_count", got_q.size() - qb, 32'd1);
    chk_elem(0, el(1'b1, 4'd0, 4'd0, 8'd7));
    chk("t4_err", err, 1'b1);

    // Reset mid-token
    do_reset();
    send_str("45");
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    send_str("6\n");
    idle(3);
    chk("t5_count", got_q.size() - qb, 32'd1);
    chk_elem(0, el(1'b1, 4'd0, 4'd0, 8'd6));

    // Reset mid-handshake drops out_valid
    do_reset();
    out_ready = 1'b0;
    send_str("9 ");
    @(negedge clk); #1;
    chk("hs_valid_before", out_valid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("hs_valid_after_rst", out_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;

    // Column overflow: 17th token dropped
    do_reset();
    for (int i = 0; i < 16; i++) send_str("1 ");
    #1;
    chk("col_err_before", err, 1'b0);
    send_str("1\n3\n");
    idle(3);
    chk("col_count", got_q.size() - qb, 32'd17);
    chk_elem(15, el(1'b0, 4'd0, 4'd15, 8'd1));
    chk_elem(16, el(1'b1, 4'd1, 4'd0, 8'd3));
    chk("col_err", err, 1'b1);

    // Row overflow wraps to row 0
    do_reset();
    for (int i = 0; i < 15; i++) send_str("1\n");
    #1;
    chk("row_err_before", err, 1'b0);
    send_str("1\n");
    #1;
    chk("row_err_after", err, 1'b1);
    send_str("2\n");
    idle(3);
    chk_elem(15, el(1'b1, 4'd15, 4'd0, 8'd1));
    chk_elem(16, el(1'b1, 4'd0, 4'd0, 8'd2));

    // Signed input / '-' handling
    do_reset();
    send_str("-128 -5 -\n");
    idle(3);
`ifdef MATRIX_PARSER_SIGNED_EN
    chk("sgn_count", got_q.size() - qb, 32'd2);
    chk_elem(0, el(1'b0, 4'd0, 4'd0, 8'h80));
    chk_elem(1, el(1'b0, 4'd0, 4'd1, 8'hFB));
`else
    chk("sgn_count", got_q.size() - qb, 32'd0);
`endif
    chk("sgn_err", err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
